writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage, directly downstream of the memory stage. Takes the memory stage's completed result (load data or ALU result), commits it to the integer register file, clears the destination's scoreboard entry, and retires the instruction. Serialises `ecall` instructions through a request/done handshake with the system-call unit, stalling the pipeline until the return value is written to x10.

## Interface
- `XLEN`, 64: data width.
- `PCW`, 32: PC width.
- `ECALL_RET_REG`, 10: destination register for the ecall return value.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  memory stage presents a completed instruction.
- `in_data`  input  XLEN  load result from the memory stage.
- `in_alu_result`  input  XLEN  ALU result from the memory stage.
- `in_ld_or_alu`  input  1  1 selects `in_data`; 0 selects `in_alu_result`.
- `in_reg_dest`  input  5  destination register; 0 means no write.
- `in_pc`  input  PCW  PC of the instruction.
- `in_is_ecall`  input  1  instruction is an ecall.
- `in_flush`  input  1  drop the instruction presented this cycle.
- `wb_busy`  output  1  stage cannot accept; upstream holds its outputs.
- `rf_wr_en`  output  1  register-file write strobe.
- `rf_wr_addr`  output  5  register-file write address.
- `rf_wr_data`  output  XLEN  register-file write data.
- `sb_clr_en`  output  1  clear the scoreboard entry at `rf_wr_addr`.
- `ecall_req`  output  1  system-call request.
- `ecall_pc`  output  PCW  PC of the pending ecall.
- `ecall_done`  input  1  system-call unit finished.
- `ecall_ret`  input  XLEN  system-call return value.
- `retire_valid`  output  1  one instruction retired this cycle.
- `last_pc`  output  PCW  PC of the most recently retired instruction.
- `instret`  output  64  retired-instruction count (see Configuration).

## Operation
- The FSM has three states: IDLE, ECALL_WAIT, ECALL_WB. `wb_busy` = (state != IDLE).
- **Accept:** `in_valid & !wb_busy` at a rising edge.
- **Flush:** an accepted instruction with `in_flush=1` is dropped. It causes no write, no retire, no ecall, and no state change.
- **Normal instruction** (accepted, not flushed, not ecall):
  - Next cycle: `retire_valid=1` and `last_pc=in_pc`.
  - If `in_reg_dest != 0`: `rf_wr_en=1` and `sb_clr_en=1`, with `rf_wr_addr=in_reg_dest` and `rf_wr_data` = selected result.
  - If `in_reg_dest == 0`: the instruction retires with no write strobe.
- **Ecall** (accepted, not flushed, `in_is_ecall=1`):
  - IDLE→ECALL_WAIT; `ecall_req=1`; `ecall_pc` latched. No retire yet.
- **ECALL_WAIT:**
  - `ecall_req` stays high until `ecall_done` is sampled.
  - On `ecall_done`: →ECALL_WB and `ecall_req` drops.
  - `in_flush` and `in_valid` are ignored in this state.
- **ECALL_WB** (one cycle):
  - `rf_wr_en=1`, `sb_clr_en=1`, `rf_wr_addr=ECALL_RET_REG`, `rf_wr_data=ecall_ret` (latched when done was sampled).
  - `retire_valid=1`, `last_pc=ecall_pc`.
  - Then →IDLE.
- `ecall_done` is ignored outside ECALL_WAIT.
- Strobes (`rf_wr_en`, `sb_clr_en`, `retire_valid`) are single-cycle pulses. They are 0 on any cycle with no accept/ECALL_WB.
- **Reset** (asynchronous, any state, including mid-ecall):
  - State→IDLE.
  - All outputs 0: `wb_busy`, `rf_wr_en`, `rf_wr_addr`, `rf_wr_data`, `sb_clr_en`, `ecall_req`, `ecall_pc`, `retire_valid`, `last_pc`, `instret`.
  - A pending ecall is abandoned.

## Timing
- All outputs are registered, except `wb_busy`, which is decoded from the state register.
- Normal latency: accept at edge N → write/retire strobes high from edge N to edge N+1.
- Back-to-back accepts retire one instruction per cycle.
- Ecall sequence:
  - Accept at edge N → `ecall_req` high after N; `wb_busy` high after N.
  - Done sampled at edge M ≥ N+1 → write strobe high from M to M+1, `ecall_req` low after M.
  - IDLE after M+1; next accept possible at edge M+2.
  - Minimum ecall occupancy is 3 cycles.

## Configuration
- `WB_INSTRET_EN`:
  - Defined: `instret` increments by 1 on every `retire_valid` pulse and wraps from 2^64−1 to 0.
  - Undefined: the counter logic is absent and `instret` is tied to 0.

## Test plan
- Reset, then accept ALU op (`in_ld_or_alu=0`, `in_alu_result=0x1234`, `in_reg_dest=5`, `in_pc=0x100`) → next cycle `rf_wr_en=1`, addr 5, data 0x1234, `sb_clr_en=1`, `retire_valid=1`, `last_pc=0x100`.
- Load with `in_ld_or_alu=1`, `in_data=0xFFFF_FFFF_FFFF_FF80`, `in_reg_dest=0` → `retire_valid=1`, `rf_wr_en=0`. Same op with `in_flush=1` → no strobes at all.
- Ecall at `in_pc=0x200`, `ecall_done` after 4 cycles with `ecall_ret=0x2A`:
  - `ecall_req` high 4 cycles, `wb_busy` held.
  - One cycle of `rf_wr_en` to x10 with data 0x2A, `last_pc=0x200`.
  - A held `in_valid` instruction is accepted 2 cycles after done.
- Assert `rst` low during ECALL_WAIT → immediately `ecall_req=0`, `wb_busy=0`, `instret=0`. `ecall_done` pulsed afterwards → no write.
- With `WB_INSTRET_EN`: 10 back-to-back retires → `instret=10`. Force counter to 2^64−1, retire once → 0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: commits memory-stage results to the register file and serialises
// ecalls through a req/done handshake. Optional WB_INSTRET_EN adds a retired-instruction counter.
module writeback_stage #(
    parameter int         XLEN          = 64,
    parameter int         PCW           = 32,
    parameter logic [4:0] ECALL_RET_REG = 5'd10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_data,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic            in_ld_or_alu,
    input  logic [4:0]      in_reg_dest,
    input  logic [PCW-1:0]  in_pc,
    input  logic            in_is_ecall,
    input  logic            in_flush,
    output logic            wb_busy,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic            sb_clr_en,
    output logic            ecall_req,
    output logic [PCW-1:0]  ecall_pc,
    input  logic            ecall_done,
    input  logic [XLEN-1:0] ecall_ret,
    output logic            retire_valid,
    output logic [PCW-1:0]  last_pc,
    output logic [63:0]     instret
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ECALL_WAIT = 2'd1,
        ECALL_WB   = 2'd2
    } state_t;

    state_t state;
    logic   accept;

    assign wb_busy = (state != IDLE);
    assign accept  = in_valid && !wb_busy;

    // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: asynchronous reset clears every output register, abandoning any pending ecall.
            state        <= IDLE;
            rf_wr_en     <= 1'b0;
            rf_wr_addr   <= '0;
            rf_wr_data   <= '0;
            sb_clr_en    <= 1'b0;
            ecall_req    <= 1'b0;
            ecall_pc     <= '0;
            retire_valid <= 1'b0;
            last_pc      <= '0;
        end else begin
            // NOTE: strobes default low each cycle so they can only ever be single-cycle pulses.
            rf_wr_en     <= 1'b0;
            sb_clr_en    <= 1'b0;
            retire_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && !in_flush) begin
                        if (in_is_ecall) begin
                            state     <= ECALL_WAIT;
                            ecall_req <= 1'b1;
                            ecall_pc  <= in_pc;
                        end else begin
                            retire_valid <= 1'b1;
                            last_pc      <= in_pc;
                            if (in_reg_dest != 5'd0) begin
                                rf_wr_en   <= 1'b1;
                                sb_clr_en  <= 1'b1;
                                rf_wr_addr <= in_reg_dest;
                                rf_wr_data <= in_ld_or_alu ? in_data : in_alu_result;
                            end
                        end
                    end
                end
                ECALL_WAIT: begin
                    // Return value is captured on the done edge; the write pulse spans ECALL_WB.
                    if (ecall_done) begin
                        state        <= ECALL_WB;
                        ecall_req    <= 1'b0;
                        rf_wr_en     <= 1'b1;
                        sb_clr_en    <= 1'b1;
                        rf_wr_addr   <= ECALL_RET_REG;
                        rf_wr_data   <= ecall_ret;
                        retire_valid <= 1'b1;
                        last_pc      <= ecall_pc;
                    end
                end
                ECALL_WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    // Counts each retire pulse one edge after it is visible; wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret <= '0;
        end else if (retire_valid) begin
            instret <= instret + 64'd1;
        end
    end
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by random
// traffic, compared against a transaction-level model of the stage's rules.
module tb_writeback_stage;

    localparam int XLEN = 64;
    localparam int PCW  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic [XLEN-1:0] in_data = '0;
    logic [XLEN-1:0] in_alu_result = '0;
    logic            in_ld_or_alu = 1'b0;
    logic [4:0]      in_reg_dest = '0;
    logic [PCW-1:0]  in_pc = '0;
    logic            in_is_ecall = 1'b0;
    logic            in_flush = 1'b0;
    logic            ecall_done = 1'b0;
    logic [XLEN-1:0] ecall_ret = '0;
    logic            wb_busy;
    logic            rf_wr_en;
    logic [4:0]      rf_wr_addr;
    logic [XLEN-1:0] rf_wr_data;
    logic            sb_clr_en;
    logic            ecall_req;
    logic [PCW-1:0]  ecall_pc;
    logic            retire_valid;
    logic [PCW-1:0]  last_pc;
    logic [63:0]     instret;

    writeback_stage #(.XLEN(XLEN), .PCW(PCW), .ECALL_RET_REG(5'd10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_alu_result(in_alu_result),
        .in_ld_or_alu(in_ld_or_alu), .in_reg_dest(in_reg_dest), .in_pc(in_pc),
        .in_is_ecall(in_is_ecall), .in_flush(in_flush),
        .wb_busy(wb_busy), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .sb_clr_en(sb_clr_en),
        .ecall_req(ecall_req), .ecall_pc(ecall_pc),
        .ecall_done(ecall_done), .ecall_ret(ecall_ret),
        .retire_valid(retire_valid), .last_pc(last_pc), .instret(instret)
    );

    always #5 clk = ~clk;

`ifdef WB_INSTRET_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: a queue holds the PC of an outstanding ecall, a flag marks
    // the single return-value writeback cycle, and expected output values.
    logic [PCW-1:0]  pend_q[$];
    bit              in_wb;
    bit              e_wr;
    logic [4:0]      e_addr;
    logic [XLEN-1:0] e_data;
    bit              e_ret;
    logic [PCW-1:0]  e_last_pc;
    longint unsigned e_instret;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_busy();
        return (pend_q.size() != 0) || in_wb;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        in_wb     = 1'b0;
        e_wr      = 1'b0;
        e_addr    = '0;
        e_data    = '0;
        e_ret     = 1'b0;
        e_last_pc = '0;
        e_instret = 0;
    endtask

    // Applies the stage's rules for one rising edge using the currently driven inputs.
    task automatic model_edge();
        if (COUNT_EN && e_ret) e_instret = e_instret + 1;
        e_wr  = 1'b0;
        e_ret = 1'b0;
        if (in_wb) begin
            in_wb = 1'b0;
        end else if (pend_q.size() != 0) begin
            if (ecall_done) begin
                e_wr      = 1'b1;
                e_addr    = 5'd10;
                e_data    = ecall_ret;
                e_ret     = 1'b1;
                e_last_pc = pend_q.pop_front();
                in_wb     = 1'b1;
            end
        end else if (in_valid && !in_flush) begin
            if (in_is_ecall) begin
                pend_q.push_back(in_pc);
            end else begin
                e_ret     = 1'b1;
                e_last_pc = in_pc;
                if (in_reg_dest != 0) begin
                    e_wr   = 1'b1;
                    e_addr = in_reg_dest;
                    e_data = in_ld_or_alu ? in_data : in_alu_result;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":busy"},    64'(wb_busy),      64'(exp_busy()));
        check({tag, ":wr_en"},   64'(rf_wr_en),     64'(e_wr));
        check({tag, ":sb_clr"},  64'(sb_clr_en),    64'(e_wr));
        check({tag, ":retire"},  64'(retire_valid), 64'(e_ret));
        check({tag, ":req"},     64'(ecall_req),    64'(pend_q.size() != 0));
        check({tag, ":instret"}, instret,           e_instret);
        if (e_ret) check({tag, ":last_pc"}, 64'(last_pc), 64'(e_last_pc));
        if (e_wr) begin
            check({tag, ":addr"}, 64'(rf_wr_addr), 64'(e_addr));
            check({tag, ":data"}, rf_wr_data, e_data);
        end
        if (pend_q.size() != 0) check({tag, ":ecall_pc"}, 64'(ecall_pc), 64'(pend_q[0]));
    endtask

    // One clock: model the edge, let the DUT take it, then check at the falling edge.
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic drive(input bit v, input bit ld, input logic [63:0] d, input logic [63:0] alu,
                         input logic [4:0] rd, input logic [31:0] pc, input bit ec, input bit fl);
        in_valid      = v;
        in_ld_or_alu  = ld;
        in_data       = d;
        in_alu_result = alu;
        in_reg_dest   = rd;
        in_pc         = pc;
        in_is_ecall   = ec;
        in_flush      = fl;
    endtask

    initial begin
        int req_cycles;
        model_reset();
        #1;
        // Reset values
        check("rst:addr",     64'(rf_wr_addr), 64'd0);
        check("rst:data",     rf_wr_data,      64'd0);
        check("rst:ecall_pc", 64'(ecall_pc),   64'd0);
        check("rst:last_pc",  64'(last_pc),    64'd0);
        check_outputs("rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ALU op into x5
        drive(1, 0, 64'd0, 64'h1234, 5'd5, 32'h100, 0, 0);
        cycle("alu");
        check("alu:addr_dir", 64'(rf_wr_addr), 64'd5);
        check("alu:data_dir", rf_wr_data, 64'h1234);
        check("alu:pc_dir",   64'(last_pc), 64'h100);

        // Load to x0: retires without a write
        drive(1, 1, 64'hFFFF_FFFF_FFFF_FF80, 64'd7, 5'd0, 32'h104, 0, 0);
        cycle("ld_x0");
        check("ld_x0:retire_dir", 64'(retire_valid), 64'd1);
        check("ld_x0:wr_dir",     64'(rf_wr_en), 64'd0);
        // Same op flushed: no strobes
        drive(1, 1, 64'hFFFF_FFFF_FFFF_FF80, 64'd7, 5'd0, 32'h108, 0, 1);
        cycle("flush");
        check("flush:retire_dir", 64'(retire_valid), 64'd0);
        // Flushed load with a real destination: still nothing
        drive(1, 1, 64'hFFFF_FFFF_FFFF_FF80, 64'd7, 5'd9, 32'h10C, 0, 1);
        cycle("flush_rd");
        drive(0, 0, 0, 0, 5'd0, 32'h0, 0, 0);
        cycle("idle");

        // Ecall at 0x200, done sampled on the 4th edge after accept; a normal op is held behind it
        drive(1, 0, 0, 0, 5'd0, 32'h200, 1, 0);
        cycle("ecall_acc");
        req_cycles = 1;
        drive(1, 0, 64'd0, 64'h55, 5'd3, 32'h204, 0, 1);  // flush must be ignored while busy
        for (int i = 0; i < 3; i++) begin
            cycle("ecall_wait");
            if (ecall_req) req_cycles++;
        end
        in_flush   = 1'b0;
        ecall_done = 1'b1;
        ecall_ret  = 64'h2A;
        cycle("ecall_done");
        ecall_done = 1'b0;
        check("ecall:req_cycles", 64'(req_cycles), 64'd4);
        check("ecall:addr_dir",   64'(rf_wr_addr), 64'd10);
        check("ecall:data_dir",   rf_wr_data, 64'h2A);
        check("ecall:pc_dir",     64'(last_pc), 64'h200);
        cycle("ecall_wb_exit");
        check("ecall:held_wait", 64'(retire_valid), 64'd0);
        cycle("held_accept");
        check("held:pc_dir", 64'(last_pc), 64'h204);
        drive(0, 0, 0, 0, 5'd0, 32'h0, 0, 0);
        cycle("idle2");

        // Reset asserted during ECALL_WAIT
        drive(1, 0, 0, 0, 5'd0, 32'h300, 1, 0);
        cycle("rst_ecall_acc");
        drive(0, 0, 0, 0, 5'd0, 32'h0, 0, 0);
        cycle("rst_ecall_wait");
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        ecall_done = 1'b1;
        ecall_ret  = 64'hDEAD;
        cycle("rst_stale_done");
        ecall_done = 1'b0;
        cycle("rst_after");

        // Ten back-to-back retires
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 64'(i * 3 + 1), 5'(i + 1), 32'h400 + 32'(i * 4), 0, 0);
            cycle("b2b");
        end
        drive(0, 0, 0, 0, 5'd0, 32'h0, 0, 0);
        cycle("b2b_end");
        check("b2b:instret_dir", instret, COUNT_EN ? 64'd10 : 64'd0);

`ifdef WB_INSTRET_EN
        dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        e_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(1, 0, 0, 64'h1, 5'd1, 32'h500, 0, 0);
        cycle("wrap_ret");
        drive(0, 0, 0, 0, 5'd0, 32'h0, 0, 0);
        cycle("wrap");
        check("wrap:instret_dir", instret, 64'd0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom), $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            ecall_done = $urandom_range(0, 2) == 0;
            ecall_ret  = {$urandom, $urandom};
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
